// File: rtl/micro_pkg.sv
// rtl/micro_pkg.sv - shared state encodings, digit limit and BCD countdown helper
package micro_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ENTRY = 3'd1,
      ST_COOK  = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int         MAX_DIGITS = 4;
   localparam logic [7:0] BCD_59     = 8'h59;

   // One-second decrement of an MM:SS BCD time; 0000 stays 0000.
   function automatic logic [15:0] bcd_dec(input logic [15:0] t);
      logic [3:0] mt;
      logic [3:0] mu;
      logic [3:0] st;
      logic [3:0] su;
      {mt, mu, st, su} = t;
      if (su != 4'd0) begin
         su = su - 4'd1;
      end else if (st != 4'd0) begin
         st = st - 4'd1;
         su = 4'd9;
      end else if ({mt, mu} != 8'h00) begin
         {st, su} = BCD_59;
         if (mu != 4'd0) begin
            mu = mu - 4'd1;
         end else begin
            mt = mt - 4'd1;
            mu = 4'd9;
         end
      end
      return {mt, mu, st, su};
   endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-flop synchronizer with edge pulses taken on bit 0
module sync_edge #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         rise,
   output logic         fall
);

   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;
   logic         prev_q, prev_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
      prev_d = sync_q[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         prev_q <= RST_VAL[0];
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign q    = sync_q;
   assign rise = sync_q[0] & ~prev_q;
   assign fall = ~sync_q[0] & prev_q;

endmodule

// File: rtl/microwave_ctrl.sv
// rtl/microwave_ctrl.sv - keypad time entry, one-second BCD countdown and magnetron control
import micro_pkg::*;

module microwave_ctrl #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] enc_b,
   input  logic       enc_dv,
   output logic       enc_en,
   input  logic       start,
   input  logic       stop,
   input  logic       door_open,
   output logic [3:0] min_t,
   output logic [3:0] min_u,
   output logic [3:0] sec_t,
   output logic [3:0] sec_u,
   output logic       mag_on,
   output logic       done
);

   localparam int            TW        = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [4:0] key_sync;
   logic       key_ev, start_ev, stop_ev, door_s;
   logic       unused_key_dv, unused_key_rise;
   logic       unused_start_lvl, unused_start_fall;
   logic       unused_stop_lvl, unused_stop_fall;
   logic       unused_door_rise, unused_door_fall;

   // enc_dv rides in bit 0 so the digit is aligned with its falling-edge event.
   sync_edge #(.W(5), .RST_VAL(5'b00001)) u_key_sync (
      .clk(clk), .rst_n(rst_n), .d({enc_b, enc_dv}),
      .q(key_sync), .rise(unused_key_rise), .fall(key_ev)
   );
   sync_edge #(.W(1)) u_start_sync (
      .clk(clk), .rst_n(rst_n), .d(start),
      .q(unused_start_lvl), .rise(start_ev), .fall(unused_start_fall)
   );
   sync_edge #(.W(1)) u_stop_sync (
      .clk(clk), .rst_n(rst_n), .d(stop),
      .q(unused_stop_lvl), .rise(stop_ev), .fall(unused_stop_fall)
   );
   sync_edge #(.W(1)) u_door_sync (
      .clk(clk), .rst_n(rst_n), .d(door_open),
      .q(door_s), .rise(unused_door_rise), .fall(unused_door_fall)
   );

   assign unused_key_dv = key_sync[0];

   state_t        state_q, state_d;
   logic [15:0]   digits_q, digits_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [TW-1:0] tick_q, tick_d;
   logic          mag_on_q, mag_on_d;
   logic          tick_last;
   logic [15:0]   dec_val;

   always_comb begin
      state_d   = state_q;
      digits_d  = digits_q;
      cnt_d     = cnt_q;
      tick_last = (tick_q == TICK_LAST);
      dec_val   = bcd_dec(digits_q);

      case (state_q)
         ST_IDLE, ST_ENTRY: begin
            if (stop_ev && state_q == ST_ENTRY) begin
               state_d  = ST_IDLE;
               digits_d = '0;
               cnt_d    = '0;
            end else if (start_ev && digits_q != 16'h0000 && !door_s) begin
               state_d = ST_COOK;
            end else if (key_ev && cnt_q < 3'(MAX_DIGITS)) begin
               digits_d = {digits_q[11:0], key_sync[4:1]};
               cnt_d    = cnt_q + 3'd1;
               state_d  = ST_ENTRY;
            end
         end
         ST_COOK: begin
            if (stop_ev || door_s) begin
               state_d = ST_PAUSE;
            end else if (tick_last) begin
               digits_d = dec_val;
               if (dec_val == 16'h0000) state_d = ST_DONE;
            end
         end
         ST_PAUSE: begin
            if (stop_ev) begin
               state_d  = ST_IDLE;
               digits_d = '0;
               cnt_d    = '0;
            end else if (start_ev && !door_s) begin
               state_d = ST_COOK;
            end
         end
         ST_DONE: begin
            // A key here only acknowledges completion; it is not loaded.
            if (stop_ev || key_ev) begin
               state_d  = ST_IDLE;
               digits_d = '0;
               cnt_d    = '0;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            digits_d = '0;
            cnt_d    = '0;
         end
      endcase

      // Counter restarts on every COOK entry and is dropped when COOK is left.
      if (state_q == ST_COOK && state_d == ST_COOK && !tick_last) begin
         tick_d = tick_q + TW'(1);
      end else begin
         tick_d = '0;
      end

      // Rises one edge after COOK entry, drops on the edge that leaves COOK.
      mag_on_d = (state_q == ST_COOK) && (state_d == ST_COOK) && !door_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         digits_q <= '0;
         cnt_q    <= '0;
         tick_q   <= '0;
         mag_on_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         digits_q <= digits_d;
         cnt_q    <= cnt_d;
         tick_q   <= tick_d;
         mag_on_q <= mag_on_d;
      end
   end

   assign {min_t, min_u, sec_t, sec_u} = digits_q;
   assign enc_en = !(state_q == ST_IDLE || state_q == ST_ENTRY);
   assign done   = (state_q == ST_DONE);
   assign mag_on = mag_on_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// tb/tb_microwave_ctrl.sv - directed self-checking bench for microwave_ctrl
module tb_microwave_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] enc_b;
   logic       enc_dv;
   logic       enc_en;
   logic       start, stop, door_open;
   logic [3:0] min_t, min_u, sec_t, sec_u;
   logic       mag_on, done;
   logic [15:0] disp;

   int n_checks = 0;
   int n_errors = 0;

   microwave_ctrl #(.TICK_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .enc_b(enc_b), .enc_dv(enc_dv), .enc_en(enc_en),
      .start(start), .stop(stop), .door_open(door_open),
      .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
      .mag_on(mag_on), .done(done)
   );

   always #5 clk = ~clk;

   assign disp = {min_t, min_u, sec_t, sec_u};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic press_key(input logic [3:0] d, input int hold);
      @(negedge clk);
      enc_b  = d;
      enc_dv = 1'b0;
      repeat (hold) @(negedge clk);
      enc_dv = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // First sampling edge is k; returns between edges k+1 and k+2.
   task automatic pulse(input logic s, input logic p);
      @(negedge clk);
      start = s;
      stop  = p;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; enc_b = 4'd0; enc_dv = 1'b1;
      start = 1'b0; stop = 1'b0; door_open = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_disp", disp, 16'h0000);
      chk("rst_enc_en", enc_en, 0);
      chk("rst_mag_on", mag_on, 0);
      chk("rst_done", done, 0);

      // 01:30 full cook with TICK_DIV=4
      press_key(4'd1, 2);
      press_key(4'd3, 2);
      press_key(4'd0, 2);
      chk("entry_0130", disp, 16'h0130);
      chk("entry_enc_en", enc_en, 0);
      pulse(1'b1, 1'b0);
      @(posedge clk); #1;                       // k+2
      chk("cook_mag_k2", mag_on, 0);
      chk("cook_enc_en", enc_en, 1);
      @(posedge clk); #1;                       // k+3
      chk("cook_mag_k3", mag_on, 1);
      chk("cook_0130", disp, 16'h0130);
      repeat (3) @(posedge clk); #1;            // k+6
      chk("cook_0129", disp, 16'h0129);
      repeat (4) @(posedge clk); #1;            // k+10
      chk("cook_0128", disp, 16'h0128);
      repeat (112) @(posedge clk); #1;          // k+122
      chk("cook_0100", disp, 16'h0100);
      repeat (4) @(posedge clk); #1;            // k+126
      chk("cook_0059", disp, 16'h0059);
      repeat (235) @(posedge clk); #1;          // k+361
      chk("cook_0001", disp, 16'h0001);
      chk("cook_0001_done", done, 0);
      chk("cook_0001_mag", mag_on, 1);
      @(posedge clk); #1;                       // k+362
      chk("done_disp", disp, 16'h0000);
      chk("done_flag", done, 1);
      chk("done_mag", mag_on, 0);
      press_key(4'd7, 2);
      chk("ack_disp", disp, 16'h0000);
      chk("ack_done", done, 0);
      chk("ack_enc_en", enc_en, 0);

      // held key, fifth digit ignored, stop from ENTRY
      press_key(4'd5, 20);
      chk("hold_one_shift", disp, 16'h0005);
      press_key(4'd9, 2);
      press_key(4'd9, 2);
      press_key(4'd9, 2);
      chk("entry_5999", disp, 16'h5999);
      press_key(4'd9, 2);
      chk("fifth_ignored", disp, 16'h5999);
      pulse(1'b0, 1'b1);
      repeat (2) @(negedge clk);
      chk("stop_entry_clr", disp, 16'h0000);
      chk("stop_entry_idle", enc_en, 0);

      // start with zero time
      pulse(1'b1, 1'b0);
      repeat (4) @(negedge clk);
      chk("zero_start_idle", enc_en, 0);
      chk("zero_start_mag", mag_on, 0);

      // door pause / resume at 00:45
      press_key(4'd4, 2);
      press_key(4'd6, 2);
      pulse(1'b1, 1'b0);
      @(posedge clk);                           // k+2
      @(posedge clk); #1;                       // k+3
      chk("door_cook_mag", mag_on, 1);
      repeat (3) @(posedge clk); #1;            // k+6
      chk("door_0045", disp, 16'h0045);
      @(negedge clk);
      door_open = 1'b1;
      repeat (3) @(posedge clk); #1;            // door k+2
      chk("door_mag_off", mag_on, 0);
      chk("door_pause_enc", enc_en, 1);
      repeat (10) @(posedge clk); #1;
      chk("pause_hold", disp, 16'h0045);
      pulse(1'b1, 1'b0);
      repeat (4) @(posedge clk); #1;
      chk("door_blocks_start", mag_on, 0);
      chk("door_blocks_disp", disp, 16'h0045);
      @(negedge clk);
      door_open = 1'b0;
      repeat (3) @(negedge clk);
      pulse(1'b1, 1'b0);
      @(posedge clk);                           // k+2
      @(posedge clk); #1;                       // k+3
      chk("resume_mag", mag_on, 1);
      repeat (2) @(posedge clk); #1;            // k+5
      chk("resume_0045", disp, 16'h0045);
      @(posedge clk); #1;                       // k+6
      chk("resume_0044", disp, 16'h0044);

      // start and stop together in COOK -> PAUSE, then stop -> IDLE
      pulse(1'b1, 1'b1);
      @(posedge clk); #1;
      chk("both_mag", mag_on, 0);
      chk("both_pause_enc", enc_en, 1);
      repeat (3) @(posedge clk); #1;
      chk("both_disp", disp, 16'h0044);
      pulse(1'b0, 1'b1);
      repeat (2) @(posedge clk); #1;
      chk("pause_stop_enc", enc_en, 0);
      chk("pause_stop_disp", disp, 16'h0000);

      // asynchronous reset mid-cook at 00:20
      press_key(4'd2, 2);
      press_key(4'd0, 2);
      pulse(1'b1, 1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      chk("rc_mag", mag_on, 1);
      chk("rc_disp", disp, 16'h0020);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rc_rst_mag", mag_on, 0);
      chk("rc_rst_disp", disp, 16'h0000);
      chk("rc_rst_enc", enc_en, 0);
      chk("rc_rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
